// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package inst_fetch_pkg;

   typedef enum logic [1:0] {
      FS_IDLE = 2'd0,
      FS_WAIT = 2'd1,
      FS_DROP = 2'd2
   } fetch_state_e;

   localparam logic [31:0] INST_NOP = 32'h0000_0000;
   localparam logic [31:0] PC_STEP  = 32'd4;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_fifo.sv
// Instruction buffer: power-of-two FIFO of {pc, inst} entries with a synchronous flush.
module fetch_fifo
   import inst_fetch_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  fetch_entry_t             push_data_i,
   input  logic                     pop_i,
   input  logic                     flush_i,
   output logic [$clog2(DEPTH):0]   count_o,
   output fetch_entry_t             head_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   fetch_entry_t   mem_q [DEPTH];
   logic [AW-1:0]  wr_ptr_q;
   logic [AW-1:0]  rd_ptr_q;
   logic [CW-1:0]  count_q;
   logic           do_push;
   logic           do_pop;

   // A push into a full buffer is legal only when the head leaves in the same cycle.
   assign do_pop  = pop_i && (count_q != '0);
   assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
   end

   assign count_o = count_q;
   assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: owns the fetch PC, keeps one imem read in flight and buffers returned words.
module inst_fetch
   import inst_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_en,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   input  logic        inst_ready,
   output logic [1:0]  dbg_state
);

   // imem handshake: imem_req and imem_addr are registered and hold until the cycle
   // imem_ack=1 completes the read; imem_rdata is only sampled in that cycle.
   localparam int CW = $clog2(DEPTH) + 1;

   fetch_state_e  state_q, state_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   addr_q, addr_d;
   logic          req_q, req_d;
   logic [CW-1:0] count;
   logic [CW-1:0] count_after;
   fetch_entry_t  head;
   logic          redir;
   logic          ack;
   logic          pop;
   logic          push;
   logic [31:0]   next_pc;

   assign redir       = redirect && cpu_en;
   assign ack         = imem_ack && req_q;
   assign pop         = inst_valid && inst_ready && cpu_en && !redir;
   assign next_pc     = addr_q + PC_STEP;
   assign count_after = count + CW'(1) - CW'(pop);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= FS_IDLE;
         fetch_pc_q <= RESET_PC;
         addr_q     <= RESET_PC;
         req_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         addr_q     <= addr_d;
         req_q      <= req_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      addr_d     = addr_q;
      req_d      = req_q;
      push       = 1'b0;
      case (state_q)
         FS_IDLE: begin
            if (redir) begin
               fetch_pc_d = redirect_pc;
               addr_d     = redirect_pc;
               req_d      = 1'b1;
               state_d    = FS_WAIT;
            end else if (cpu_en && (count < CW'(DEPTH))) begin
               addr_d  = fetch_pc_q;
               req_d   = 1'b1;
               state_d = FS_WAIT;
            end
         end
         FS_WAIT: begin
            if (redir) begin
               fetch_pc_d = redirect_pc;
               // The in-flight read cannot be withdrawn; if it completes now, just retarget.
               if (ack) addr_d = redirect_pc;
               else     state_d = FS_DROP;
            end else if (ack) begin
               push       = 1'b1;
               fetch_pc_d = next_pc;
               if (cpu_en && (count_after < CW'(DEPTH))) begin
                  addr_d = next_pc;
               end else begin
                  req_d   = 1'b0;
                  state_d = FS_IDLE;
               end
            end
         end
         FS_DROP: begin
            if (redir) fetch_pc_d = redirect_pc;
            if (ack) begin
               if (cpu_en) begin
                  addr_d  = redir ? redirect_pc : fetch_pc_q;
                  state_d = FS_WAIT;
               end else begin
                  req_d   = 1'b0;
                  state_d = FS_IDLE;
               end
            end
         end
         default: begin
            req_d   = 1'b0;
            state_d = FS_IDLE;
         end
      endcase
   end

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk         (clk),
      .rst         (rst),
      .push_i      (push),
      .push_data_i ('{pc: addr_q, inst: imem_rdata}),
      .pop_i       (pop),
      .flush_i     (redir),
      .count_o     (count),
      .head_o      (head)
   );

   assign imem_req   = req_q;
   assign imem_addr  = addr_q;
   assign inst_valid = (count != '0);
   assign inst       = inst_valid ? head.inst : INST_NOP;
   assign inst_pc    = inst_valid ? head.pc : 32'h0;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a latency-programmable instruction-memory responder.
module tb_inst_fetch;
   import inst_fetch_pkg::*;

   logic        clk;
   logic        rst;
   logic        cpu_en;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_ready;
   logic [1:0]  dbg_state;

   int checks   = 0;
   int failures = 0;
   int mem_lat  = 1;
   int age      = 0;

   inst_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .cpu_en     (cpu_en),
      .redirect   (redirect),
      .redirect_pc(redirect_pc),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .inst_valid (inst_valid),
      .inst       (inst),
      .inst_pc    (inst_pc),
      .inst_ready (inst_ready),
      .dbg_state  (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
   endfunction

   // Memory: ack arrives when the request has been visible for more than mem_lat cycles.
   always @(posedge clk) begin
      #2;
      if (rst || !imem_req) begin
         imem_ack = 1'b0;
         age      = 0;
      end else if (imem_ack) begin
         imem_ack = 1'b0;
         age      = 1;
      end else begin
         age = age + 1;
         if (age > mem_lat) imem_ack = 1'b1;
      end
      imem_rdata = imem_ack ? mem_word(imem_addr) : 32'hDEAD_BEEF;
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #3;
   endtask

   task automatic do_reset();
      rst         = 1'b1;
      cpu_en      = 1'b1;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      inst_ready  = 1'b1;
      mem_lat     = 1;
      repeat (2) tick();
      rst = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1;
      #1;
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", imem_req); end
      checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", imem_addr); end
      checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", inst_valid); end
      checks++; if (inst !== 32'h0) begin failures++; $display("FAIL reset_inst got=%h exp=0", inst); end
      checks++; if (inst_pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", inst_pc); end
      checks++; if (dbg_state !== FS_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, FS_IDLE); end
   endtask

   task automatic test_stream();
      logic [31:0] exp_q[$];
      logic [31:0] ack_exp = 32'h0;
      int last_pop = -1;
      int pops = 0;
      do_reset();
      for (int i = 0; i < 6; i++) exp_q.push_back(32'(i * 4));
      for (int cyc = 0; cyc < 60 && exp_q.size() > 0; cyc++) begin
         if (imem_req && imem_ack) begin
            checks++; if (imem_addr !== ack_exp) begin failures++; $display("FAIL stream_addr got=%h exp=%h", imem_addr, ack_exp); end
            ack_exp += 32'd4;
         end
         if (inst_valid) begin
            checks++; if (inst_pc !== exp_q[0] || inst !== mem_word(exp_q[0])) begin
               failures++; $display("FAIL stream_data pc=%h inst=%h exp_pc=%h exp_inst=%h", inst_pc, inst, exp_q[0], mem_word(exp_q[0]));
            end
            if (last_pop < 0) begin
               checks++; if (cyc != 3) begin failures++; $display("FAIL stream_first_latency got=%0d exp=3", cyc); end
            end else begin
               checks++; if (cyc - last_pop != 2) begin failures++; $display("FAIL stream_gap got=%0d exp=2", cyc - last_pop); end
            end
            last_pop = cyc;
            void'(exp_q.pop_front());
            pops++;
         end
         tick();
      end
      checks++; if (pops != 6) begin failures++; $display("FAIL stream_count got=%0d exp=6", pops); end
   endtask

   task automatic test_backpressure();
      logic [31:0] exp_q[$];
      int acks = 0;
      bit seen_req = 1'b0;
      do_reset();
      inst_ready = 1'b0;
      for (int cyc = 0; cyc < 12; cyc++) begin
         if (imem_req && imem_ack) begin
            checks++; if (imem_addr !== 32'(acks * 4)) begin failures++; $display("FAIL bp_addr got=%h exp=%h", imem_addr, 32'(acks * 4)); end
            acks++;
         end
         tick();
      end
      checks++; if (acks != 2) begin failures++; $display("FAIL bp_pushes got=%0d exp=2", acks); end
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL bp_req_idle got=%b exp=0", imem_req); end
      checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0) begin failures++; $display("FAIL bp_head valid=%b pc=%h exp=1/0", inst_valid, inst_pc); end
      checks++; if (dbg_state !== FS_IDLE) begin failures++; $display("FAIL bp_state got=%0d exp=%0d", dbg_state, FS_IDLE); end
      inst_ready = 1'b1;
      exp_q = '{32'h0, 32'h4, 32'h8};
      for (int cyc = 0; cyc < 30 && exp_q.size() > 0; cyc++) begin
         if (imem_req && !seen_req) begin
            seen_req = 1'b1;
            checks++; if (imem_addr !== 32'h8) begin failures++; $display("FAIL bp_resume_addr got=%h exp=8", imem_addr); end
         end
         if (inst_valid) begin
            checks++; if (inst_pc !== exp_q[0]) begin failures++; $display("FAIL bp_pop_pc got=%h exp=%h", inst_pc, exp_q[0]); end
            void'(exp_q.pop_front());
         end
         tick();
      end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL bp_drain remaining=%0d exp=0", exp_q.size()); end
   endtask

   task automatic test_redirect();
      logic [31:0] exp_q[$];
      bit found = 1'b0;
      int waited = 0;
      do_reset();
      for (int cyc = 0; cyc < 40 && !found; cyc++) begin
         if (imem_req && imem_addr == 32'h8) found = 1'b1;
         else tick();
      end
      checks++; if (!found || imem_ack !== 1'b0) begin failures++; $display("FAIL redir_setup found=%b ack=%b exp=1/0", found, imem_ack); end
      mem_lat     = 3;
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0100;
      tick();
      redirect = 1'b0;
      checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL redir_flush valid=%b exp=0", inst_valid); end
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) begin failures++; $display("FAIL redir_hold req=%b addr=%h exp=1/8", imem_req, imem_addr); end
      checks++; if (dbg_state !== FS_DROP) begin failures++; $display("FAIL redir_state got=%0d exp=%0d", dbg_state, FS_DROP); end
      while (!imem_ack && waited < 10) begin
         tick();
         waited++;
      end
      checks++; if (waited != 2) begin failures++; $display("FAIL redir_ack_wait got=%0d exp=2", waited); end
      tick();
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 || inst_valid !== 1'b0) begin
         failures++; $display("FAIL redir_restart req=%b addr=%h valid=%b exp=1/100/0", imem_req, imem_addr, inst_valid);
      end
      exp_q = '{32'h100, 32'h104};
      for (int cyc = 0; cyc < 30 && exp_q.size() > 0; cyc++) begin
         if (inst_valid) begin
            checks++; if (inst_pc !== exp_q[0] || inst !== mem_word(exp_q[0])) begin
               failures++; $display("FAIL redir_pop pc=%h inst=%h exp_pc=%h", inst_pc, inst, exp_q[0]);
            end
            void'(exp_q.pop_front());
         end
         tick();
      end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL redir_drain remaining=%0d exp=0", exp_q.size()); end
   endtask

   task automatic test_redirect_ack_pop();
      logic [31:0] exp_q[$];
      bit found = 1'b0;
      do_reset();
      inst_ready = 1'b0;
      for (int cyc = 0; cyc < 40 && !found; cyc++) begin
         if (imem_ack && imem_addr == 32'h4) found = 1'b1;
         else tick();
      end
      checks++; if (!found || inst_valid !== 1'b1 || inst_pc !== 32'h0) begin
         failures++; $display("FAIL rap_setup found=%b valid=%b pc=%h exp=1/1/0", found, inst_valid, inst_pc);
      end
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0200;
      inst_ready  = 1'b1;
      tick();
      redirect = 1'b0;
      checks++; if (inst_valid !== 1'b0) begin failures++; $display("FAIL rap_flush valid=%b exp=0", inst_valid); end
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin failures++; $display("FAIL rap_req req=%b addr=%h exp=1/200", imem_req, imem_addr); end
      checks++; if (dbg_state !== FS_WAIT) begin failures++; $display("FAIL rap_state got=%0d exp=%0d", dbg_state, FS_WAIT); end
      exp_q = '{32'h200, 32'h204, 32'h208};
      for (int cyc = 0; cyc < 30 && exp_q.size() > 0; cyc++) begin
         if (inst_valid) begin
            checks++; if (inst_pc !== exp_q[0]) begin failures++; $display("FAIL rap_pop got=%h exp=%h", inst_pc, exp_q[0]); end
            void'(exp_q.pop_front());
         end
         tick();
      end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL rap_drain remaining=%0d exp=0", exp_q.size()); end
   endtask

   task automatic test_cpu_en();
      logic [31:0] exp_q[$];
      bit seen_req = 1'b0;
      int waited = 0;
      do_reset();
      mem_lat = 2;
      while (!imem_req && waited < 10) begin
         tick();
         waited++;
      end
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL en_first_req req=%b addr=%h exp=1/0", imem_req, imem_addr); end
      cpu_en = 1'b0;
      waited = 0;
      while (!imem_ack && waited < 10) begin
         tick();
         waited++;
      end
      tick();
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL en_no_req got=%b exp=0", imem_req); end
      checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || inst !== mem_word(32'h0)) begin
         failures++; $display("FAIL en_pushed valid=%b pc=%h inst=%h exp=1/0/%h", inst_valid, inst_pc, inst, mem_word(32'h0));
      end
      redirect    = 1'b1;
      redirect_pc = 32'h0000_0300;
      repeat (3) tick();
      redirect = 1'b0;
      checks++; if (inst_valid !== 1'b1 || inst_pc !== 32'h0 || imem_req !== 1'b0) begin
         failures++; $display("FAIL en_held valid=%b pc=%h req=%b exp=1/0/0", inst_valid, inst_pc, imem_req);
      end
      cpu_en = 1'b1;
      exp_q = '{32'h0, 32'h4, 32'h8};
      for (int cyc = 0; cyc < 40 && exp_q.size() > 0; cyc++) begin
         if (imem_req && !seen_req) begin
            seen_req = 1'b1;
            checks++; if (imem_addr !== 32'h4) begin failures++; $display("FAIL en_resume_addr got=%h exp=4", imem_addr); end
         end
         if (inst_valid) begin
            checks++; if (inst_pc !== exp_q[0]) begin failures++; $display("FAIL en_pop got=%h exp=%h", inst_pc, exp_q[0]); end
            void'(exp_q.pop_front());
         end
         tick();
      end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL en_drain remaining=%0d exp=0", exp_q.size()); end
   endtask

   task automatic test_wrap();
      logic [31:0] exp_q[$];
      do_reset();
      cpu_en = 1'b0;
      repeat (2) tick();
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL wrap_stalled req=%b exp=0", imem_req); end
      cpu_en      = 1'b1;
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      tick();
      redirect = 1'b0;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
         failures++; $display("FAIL wrap_req req=%b addr=%h exp=1/fffffffc", imem_req, imem_addr);
      end
      exp_q = '{32'hFFFF_FFFC, 32'h0, 32'h4};
      for (int cyc = 0; cyc < 30 && exp_q.size() > 0; cyc++) begin
         if (inst_valid) begin
            checks++; if (inst_pc !== exp_q[0]) begin failures++; $display("FAIL wrap_pop got=%h exp=%h", inst_pc, exp_q[0]); end
            void'(exp_q.pop_front());
         end
         tick();
      end
      checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL wrap_drain remaining=%0d exp=0", exp_q.size()); end
   endtask

   task automatic test_async_reset();
      bit found = 1'b0;
      do_reset();
      inst_ready = 1'b0;
      for (int cyc = 0; cyc < 40 && !found; cyc++) begin
         if (imem_req && imem_addr == 32'h4) found = 1'b1;
         else tick();
      end
      checks++; if (!found || inst_valid !== 1'b1 || dbg_state !== FS_WAIT) begin
         failures++; $display("FAIL arst_setup found=%b valid=%b state=%0d exp=1/1/%0d", found, inst_valid, dbg_state, FS_WAIT);
      end
      #2;
      rst = 1'b1;
      #1;
      checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0) begin failures++; $display("FAIL arst_req req=%b addr=%h exp=0/0", imem_req, imem_addr); end
      checks++; if (inst_valid !== 1'b0 || inst !== 32'h0 || inst_pc !== 32'h0) begin
         failures++; $display("FAIL arst_head valid=%b inst=%h pc=%h exp=0/0/0", inst_valid, inst, inst_pc);
      end
      checks++; if (dbg_state !== FS_IDLE) begin failures++; $display("FAIL arst_state got=%0d exp=%0d", dbg_state, FS_IDLE); end
      repeat (2) tick();
      rst        = 1'b0;
      inst_ready = 1'b1;
      tick();
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL arst_restart req=%b addr=%h exp=1/0", imem_req, imem_addr); end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      rst         = 1'b1;
      cpu_en      = 1'b0;
      redirect    = 1'b0;
      redirect_pc = 32'h0;
      inst_ready  = 1'b0;
      imem_ack    = 1'b0;
      imem_rdata  = 32'h0;
      repeat (2) tick();
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_redirect_ack_pop();
      test_cpu_en();
      test_wrap();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
